alu_mdu_core: RTL and testbench

//  Parametrised successor of the 8-bit ALU datapath: WIDTH-bit ALU with valid/ready handshake on both sides,

---
 rtl/alu_mdu_core.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_alu_mdu_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_core.sv
// ---------------------------------------------------------------------------
// alu_mdu_core
//   WIDTH-bit ALU with a valid/ready handshake on both sides, one output
//   holding register and an iterative shift-add multiplier / restoring
//   divider. Only one operation is in flight at a time.
//
//   Configuration macro: ALU_DIV_EN
//     defined   -> restoring divider built, DIV takes WIDTH cycles
//                  (divide-by-zero short-circuits in one cycle)
//     undefined -> no divider, op 6 completes in one cycle with zero
//                  results and the overflow flag set
//
//   Parameters
//     WIDTH     operand/result width (even, >= 8)
//     MUL_FAST  1: single-cycle combinational MUL, 0: iterative MUL
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     op_code               operation select
//     src1, src2            operands A and B
//     srcCy, srcAc          carry/borrow in, aux carry in
//     valid_in / ready_in   request handshake (ready_in is combinational)
//     des1, des2            primary / secondary result
//     desCy, desAC, desOv   carry, aux carry, overflow flags
//     valid_out / ready_out result handshake
// ---------------------------------------------------------------------------
module alu_mdu_core #(
  parameter int WIDTH    = 8,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             srcCy,
  input  logic             srcAc,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] des1,
  output logic [WIDTH-1:0] des2,
  output logic             desCy,
  output logic             desAC,
  output logic             desOv,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ITER} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             ac_in_q, ac_in_d;
`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
`endif
  logic [WIDTH-1:0] des1_q, des1_d;
  logic [WIDTH-1:0] des2_q, des2_d;
  logic             cy_q, cy_d;
  logic             ac_q, ac_d;
  logic             ov_q, ov_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0]   res1, res2;
  logic               res_cy, res_ac, res_ov, start_iter, carry_in;
  logic [WIDTH:0]     sum_ext;
  logic [2*WIDTH-1:0] prod;
  logic               accept;

  logic [WIDTH:0]     mul_add;
  logic [WIDTH-1:0]   mul_acc, mul_mq;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_acc, div_mq;
`endif

  assign accept = valid_in && ready_in;
  assign prod   = {{WIDTH{1'b0}}, src1} * {{WIDTH{1'b0}}, src2};

  // Single-cycle result for every op; MUL/DIV that need iterating only raise start_iter.
  // Aux carry is recovered from bit 4 as r4^a4^b4, which holds for both add and subtract.
  always_comb begin
    res1       = '0;
    res2       = '0;
    res_cy     = srcCy;
    res_ac     = srcAc;
    res_ov     = 1'b0;
    start_iter = 1'b0;
    carry_in   = 1'b0;
    sum_ext    = '0;
    case (op_code)
      4'h0, 4'h1: begin
        carry_in = op_code[0] & srcCy;
        sum_ext  = {1'b0, src1} + {1'b0, src2} + {{WIDTH{1'b0}}, carry_in};
        res1     = sum_ext[WIDTH-1:0];
        res_cy   = sum_ext[WIDTH];
        res_ac   = sum_ext[4] ^ src1[4] ^ src2[4];
        res_ov   = ~(src1[WIDTH-1] ^ src2[WIDTH-1]) & (src1[WIDTH-1] ^ sum_ext[WIDTH-1]);
      end
      4'h2: begin
        sum_ext = {1'b0, src1} - {1'b0, src2} - {{WIDTH{1'b0}}, srcCy};
        res1    = sum_ext[WIDTH-1:0];
        res_cy  = sum_ext[WIDTH];
        res_ac  = sum_ext[4] ^ src1[4] ^ src2[4];
        res_ov  = (src1[WIDTH-1] ^ src2[WIDTH-1]) & (src1[WIDTH-1] ^ sum_ext[WIDTH-1]);
      end
      4'h3: res1 = src1 + 1'b1;
      4'h4: res1 = src1 - 1'b1;
      4'h5: begin
        if (MUL_FAST) begin
          res1   = prod[WIDTH-1:0];
          res2   = prod[2*WIDTH-1:WIDTH];
          res_ov = |prod[2*WIDTH-1:WIDTH];
          res_cy = 1'b0;
        end else begin
          start_iter = 1'b1;
        end
      end
      4'h6: begin
        res_cy = 1'b0;
`ifdef ALU_DIV_EN
        if (src2 == '0) begin
          res1   = '1;
          res2   = src1;
          res_ov = 1'b1;
        end else begin
          start_iter = 1'b1;
        end
`else
        res_ov = 1'b1;
`endif
      end
      4'h7: res1 = src1 & src2;
      4'h8: res1 = src1 | src2;
      4'h9: res1 = src1 ^ src2;
      4'hA: res1 = ~src1;
      4'hB: res1 = {src1[WIDTH-2:0], src1[WIDTH-1]};
      4'hC: res1 = {src1[0], src1[WIDTH-1:1]};
      4'hD: begin
        res1   = {src1[WIDTH-2:0], srcCy};
        res_cy = src1[WIDTH-1];
      end
      4'hE: begin
        res1   = {srcCy, src1[WIDTH-1:1]};
        res_cy = src1[0];
      end
      default: res1 = src1;
    endcase
  end

  // One iteration step: shift-add multiply keeps the product in {acc, mq};
  // restoring divide keeps the remainder in acc and shifts quotient bits into mq.
  always_comb begin
    mul_add = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    mul_acc = mul_add[WIDTH:1];
    mul_mq  = {mul_add[0], mq_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_acc   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    div_mq    = {mq_q[WIDTH-2:0], div_ge};
`endif
  end

  // Next-state logic: iterate only for multi-cycle MUL/DIV, return when the count expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && start_iter) state_d = ITER;
      ITER:    if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output-register updates; a new result may load on the same edge
  // the consumer takes the previous one.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opb_d   = opb_q;
    ac_in_d = ac_in_q;
`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
`endif
    des1_d  = des1_q;
    des2_d  = des2_q;
    cy_d    = cy_q;
    ac_d    = ac_q;
    ov_d    = ov_q;
    valid_d = valid_q;
    if (valid_q && ready_out) valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        if (start_iter) begin
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          mq_d    = src1;
          opb_d   = src2;
          ac_in_d = srcAc;
`ifdef ALU_DIV_EN
          is_div_d = (op_code == 4'h6);
`endif
        end else begin
          des1_d  = res1;
          des2_d  = res2;
          cy_d    = res_cy;
          ac_d    = res_ac;
          ov_d    = res_ov;
          valid_d = 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      acc_d = mul_acc;
      mq_d  = mul_mq;
`ifdef ALU_DIV_EN
      if (is_div_q) begin
        acc_d = div_acc;
        mq_d  = div_mq;
      end
`endif
      if (cnt_q == CW'(1)) begin
        des1_d  = mq_d;
        des2_d  = acc_d;
        cy_d    = 1'b0;
        ac_d    = ac_in_q;
        ov_d    = |mul_acc;
`ifdef ALU_DIV_EN
        if (is_div_q) ov_d = 1'b0;
`endif
        valid_d = 1'b1;
      end
    end
  end

  // Output decode: request side is ready only when idle and the holding register is free.
  always_comb begin
    ready_in  = (state_q == IDLE) && (!valid_q || ready_out);
    des1      = des1_q;
    des2      = des2_q;
    desCy     = cy_q;
    desAC     = ac_q;
    desOv     = ov_q;
    valid_out = valid_q;
  end

  // State and data registers; reset aborts any iteration without emitting a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opb_q   <= '0;
      ac_in_q <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
      des1_q  <= '0;
      des2_q  <= '0;
      cy_q    <= 1'b0;
      ac_q    <= 1'b0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opb_q   <= opb_d;
      ac_in_q <= ac_in_d;
`ifdef ALU_DIV_EN
      is_div_q <= is_div_d;
`endif
      des1_q  <= des1_d;
      des2_q  <= des2_d;
      cy_q    <= cy_d;
      ac_q    <= ac_d;
      ov_q    <= ov_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_core
//   Bench for alu_mdu_core (WIDTH=8, MUL_FAST=0). A behavioural model built
//   from plain integer arithmetic predicts every result and its arrival
//   cycle; a compare process checks the DUT against it on every falling
//   edge. Directed cases pin the model with hand-computed literals, then a
//   long randomized run exercises back-pressure, iteration and reset.
// ---------------------------------------------------------------------------
module tb_alu_mdu_core;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         cy;
    logic         ac;
    logic         ov;
    int           lat;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   op_code;
  logic [W-1:0] src1, src2;
  logic         srcCy, srcAc, valid_in, ready_in;
  logic [W-1:0] des1, des2;
  logic         desCy, desAC, desOv, valid_out, ready_out;

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   acceptCyc  = 0;
  logic mvalid     = 1'b0;
  int   mbusy      = 0;
  bit   live       = 1'b0;
  res_t mout, mpend;

  alu_mdu_core #(.WIDTH(W), .MUL_FAST(1'b0)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .src1(src1), .src2(src2),
    .srcCy(srcCy), .srcAc(srcAc), .valid_in(valid_in), .ready_in(ready_in),
    .des1(des1), .des2(des2), .desCy(desCy), .desAC(desAC), .desOv(desOv),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  // Free-running clock and a cycle counter used for latency measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference behaviour of one operation using integer arithmetic.
  function automatic res_t refModel(input logic [3:0] op, input int a, input int b,
                                    input int cy, input int ac);
    res_t r;
    int s, cin, sa, sb, sr, p;
    r.d1 = '0; r.d2 = '0; r.cy = cy[0]; r.ac = ac[0]; r.ov = 1'b0; r.lat = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      4'h0, 4'h1: begin
        cin  = (op == 4'h1) ? cy : 0;
        s    = a + b + cin;
        r.d1 = W'(s % 256);
        r.cy = (s > 255);
        r.ac = ((a % 16) + (b % 16) + cin) > 15;
        sr   = sa + sb + cin;
        r.ov = (sr > 127) || (sr < -128);
      end
      4'h2: begin
        s    = a - b - cy;
        r.d1 = W'((s + 512) % 256);
        r.cy = (s < 0);
        r.ac = ((a % 16) - (b % 16) - cy) < 0;
        sr   = sa - sb - cy;
        r.ov = (sr > 127) || (sr < -128);
      end
      4'h3: r.d1 = W'((a + 1) % 256);
      4'h4: r.d1 = W'((a + 255) % 256);
      4'h5: begin
        p     = a * b;
        r.d1  = W'(p % 256);
        r.d2  = W'(p / 256);
        r.ov  = (p / 256) != 0;
        r.cy  = 1'b0;
        r.lat = W;
      end
      4'h6: begin
        r.cy = 1'b0;
`ifdef ALU_DIV_EN
        if (b == 0) begin
          r.d1 = W'(255);
          r.d2 = W'(a);
          r.ov = 1'b1;
        end else begin
          r.d1  = W'(a / b);
          r.d2  = W'(a % b);
          r.lat = W;
        end
`else
        r.ov = 1'b1;
`endif
      end
      4'h7: r.d1 = W'(a & b);
      4'h8: r.d1 = W'(a | b);
      4'h9: r.d1 = W'(a ^ b);
      4'hA: r.d1 = W'(255 - a);
      4'hB: r.d1 = W'((a * 2) % 256 + a / 128);
      4'hC: r.d1 = W'(a / 2 + (a % 2) * 128);
      4'hD: begin
        r.d1 = W'((a * 2) % 256 + cy);
        r.cy = (a / 128) != 0;
      end
      4'hE: begin
        r.d1 = W'(a / 2 + cy * 128);
        r.cy = (a % 2) != 0;
      end
      default: r.d1 = W'(a);
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 8'h7F;
      3:       return 8'h80;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request and hold it until the core takes it; operands are
  // scrambled right after acceptance so that latching is exercised.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cy, input logic ac);
    int n;
    @(posedge clk);
    #1;
    op_code = op; src1 = a; src2 = b; srcCy = cy; srcAc = ac; valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready_in !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_in !== 1'b1) checkOutput("accept wait", 32'(ready_in), 32'd1);
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    valid_in  = 1'b0;
    op_code   = 4'($urandom);
    src1      = W'($urandom);
    src2      = W'($urandom);
    srcCy     = 1'($urandom);
    srcAc     = 1'($urandom);
  endtask

  // Wait for a result and compare it with hand-computed literals and the expected edge count.
  task automatic expectResult(input string name, input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic cy, input logic ac, input logic ov, input int edges);
    int n;
    n = 0;
    @(negedge clk);
    while (valid_out !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " valid"}, 32'(valid_out), 32'd1);
    checkOutput({name, " latency"}, 32'(cyc - acceptCyc), 32'(edges));
    checkOutput({name, " des1"}, 32'(des1), 32'(d1));
    checkOutput({name, " des2"}, 32'(des2), 32'(d2));
    checkOutput({name, " flags"}, 32'({desCy, desAC, desOv}), 32'({cy, ac, ov}));
  endtask

  // Behavioural model: tracks the holding register and when an iterative result appears.
  always @(posedge clk) begin : model
    bit   mready;
    res_t r;
    if (reset) begin
      live     = 1'b1;
      mvalid   = 1'b0;
      mbusy    = 0;
      mout.d1  = '0; mout.d2 = '0;
      mout.cy  = 1'b0; mout.ac = 1'b0; mout.ov = 1'b0;
    end else if (live) begin
      mready = (mbusy == 0) && (!mvalid || ready_out);
      if (mvalid && ready_out) mvalid = 1'b0;
      if (mbusy > 0) begin
        mbusy--;
        if (mbusy == 0) begin
          mvalid = 1'b1;
          mout   = mpend;
        end
      end else if (valid_in && mready) begin
        r = refModel(op_code, int'(src1), int'(src2), int'(srcCy), int'(srcAc));
        if (r.lat == 0) begin
          mvalid = 1'b1;
          mout   = r;
        end else begin
          mbusy = r.lat;
          mpend = r;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs with the model.
  always @(negedge clk) begin
    if (live) begin
      checkOutput("valid_out", 32'(valid_out), 32'(mvalid));
      checkOutput("ready_in", 32'(ready_in), 32'((mbusy == 0) && (!mvalid || ready_out)));
      if (mvalid) begin
        checkOutput("des1", 32'(des1), 32'(mout.d1));
        checkOutput("des2", 32'(des2), 32'(mout.d2));
        checkOutput("desCy", 32'(desCy), 32'(mout.cy));
        checkOutput("desAC", 32'(desAC), 32'(mout.ac));
        checkOutput("desOv", 32'(desOv), 32'(mout.ov));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, valid_out=%0b ready_in=%0b", valid_out, ready_in);
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    op_code = '0; src1 = '0; src2 = '0; srcCy = 1'b0; srcAc = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset ready_in", 32'(ready_in), 32'd1);
    checkOutput("reset des1", 32'(des1), 32'd0);
    checkOutput("reset des2", 32'(des2), 32'd0);
    checkOutput("reset flags", 32'({desCy, desAC, desOv}), 32'd0);

    applyStimulus(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0);
    expectResult("add 7F+01", 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(4'h2, 8'h00, 8'h01, 1'b0, 1'b0);
    expectResult("subb 00-01", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(4'hD, 8'h80, 8'h5A, 1'b1, 1'b0);
    expectResult("rlc 80", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(4'h5, 8'h50, 8'hA0, 1'b0, 1'b1);
    expectResult("mul 50*A0", 8'h00, 8'h32, 1'b0, 1'b1, 1'b1, W);
`ifdef ALU_DIV_EN
    applyStimulus(4'h6, 8'hFB, 8'h12, 1'b1, 1'b0);
    expectResult("div FB/12", 8'h0D, 8'h11, 1'b0, 1'b0, 1'b0, W);
    applyStimulus(4'h6, 8'h37, 8'h00, 1'b0, 1'b1);
    expectResult("div 37/00", 8'hFF, 8'h37, 1'b0, 1'b1, 1'b1, 0);
`else
    applyStimulus(4'h6, 8'h37, 8'h12, 1'b1, 1'b1);
    expectResult("div disabled", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 0);
`endif

    // Back-pressure: the held ADD result must stay put while a second op waits.
    applyStimulus(4'h0, 8'h12, 8'h34, 1'b0, 1'b0);
    ready_out = 1'b0;
    op_code = 4'h9; src1 = 8'hF0; src2 = 8'h3C; srcCy = 1'b0; srcAc = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall ready_in", 32'(ready_in), 32'd0);
      checkOutput("stall des1", 32'(des1), 32'h46);
      checkOutput("stall valid_out", 32'(valid_out), 32'd1);
    end
    @(posedge clk);
    #1 ready_out = 1'b1;
    @(negedge clk);
    checkOutput("release ready_in", 32'(ready_in), 32'd1);
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    valid_in  = 1'b0;
    expectResult("xor back-to-back", 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 0);

    // Reset four steps into an iteration: nothing may ever come out.
`ifdef ALU_DIV_EN
    applyStimulus(4'h6, 8'hFB, 8'h12, 1'b0, 1'b0);
`else
    applyStimulus(4'h5, 8'hFB, 8'h12, 1'b0, 1'b0);
`endif
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort valid_out", 32'(valid_out), 32'd0);
    checkOutput("abort ready_in", 32'(ready_in), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("abort no result", 32'(valid_out), 32'd0);
    end

    // Randomized traffic with random back-pressure and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 499) == 0);
      ready_out = ($urandom_range(0, 3) != 0);
      valid_in  = 1'($urandom);
      op_code   = 4'($urandom);
      src1      = pick();
      src2      = pick();
      srcCy     = 1'($urandom);
      srcAc     = 1'($urandom);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
